game_timer: RTL

//  Level countdown timer. Produces the 12-bit seconds value that the info panel

---
 rtl/game_timer_pkg.sv | 15 +
 rtl/tick_gen.sv | 36 +++
 rtl/game_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared definitions for the level timer: state encoding, timer width and the pixel-clock rate.
package game_timer_pkg;

    localparam int unsigned TIMER_W        = 12;
    localparam int unsigned CLK_HZ_DEFAULT = 65_000_000;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPaused  = 3'd2,
        StExpired = 3'd3,
        StDrain   = 3'd4
    } gt_state_e;

endpackage

// File: rtl/tick_gen.sv
// Modulo-N strobe counter: counts 0..N-1 while enabled, strobes on the last count, sync clear.
module tick_gen #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == Last) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && !clr && (count_q == Last);

endmodule

// File: rtl/game_timer.sv
// Level countdown timer: counts seconds down in RUN, flags time-out, and drains leftover
// seconds into bonus ticks at level end. All outputs are registered.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned        CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned        DRAIN_DIV    = 1_000_000,
    parameter logic [TIMER_W-1:0] DEFAULT_TIME = 12'd200
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] level_time,
    input  logic               start,
    input  logic               pause,
    input  logic               level_done,
    output logic [TIMER_W-1:0] timer,
    output logic               running,
    output logic               time_up,
    output logic               bonus_tick,
    output logic               drain_done
);

    gt_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               running_q;
    logic               time_up_q, time_up_d;
    logic               bonus_q, bonus_d;
    logic               drain_done_q, drain_done_d;

    logic sec_en, sec_clr, sec_tick;
    logic drn_en, drn_clr, drn_tick;

    tick_gen #(
        .N (CLK_HZ)
    ) u_sec_div (
        .clk   (pclk),
        .rst_n (rst_n),
        .en    (sec_en),
        .clr   (sec_clr),
        .tick  (sec_tick)
    );

    tick_gen #(
        .N (DRAIN_DIV)
    ) u_drain_div (
        .clk   (pclk),
        .rst_n (rst_n),
        .en    (drn_en),
        .clr   (drn_clr),
        .tick  (drn_tick)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        time_up_d    = 1'b0;
        bonus_d      = 1'b0;
        drain_done_d = 1'b0;
        sec_en       = 1'b0;
        sec_clr      = 1'b0;
        drn_en       = 1'b0;
        drn_clr      = 1'b0;

        if (load) begin
            timer_d = level_time;
            sec_clr = 1'b1;
            drn_clr = 1'b1;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (timer_q != '0) begin
                            state_d = StRun;
                            sec_clr = 1'b1;
                        end else begin
                            state_d   = StExpired;
                            time_up_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    // level_done and pause both swallow a coincident tick
                    if (level_done) begin
                        state_d = StDrain;
                        drn_clr = 1'b1;
                    end else if (pause) begin
                        state_d = StPaused;
                    end else begin
                        sec_en = 1'b1;
                        if (sec_tick && timer_q != '0) begin
                            timer_d = timer_q - TIMER_W'(1);
                            if (timer_q == TIMER_W'(1)) begin
                                state_d   = StExpired;
                                time_up_d = 1'b1;
                            end
                        end
                    end
                end
                StPaused: begin
                    if (level_done) begin
                        state_d = StDrain;
                        drn_clr = 1'b1;
                    end else if (!pause) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                    timer_d = '0;
                end
                StDrain: begin
                    if (timer_q == '0) begin
                        state_d      = StIdle;
                        drain_done_d = 1'b1;
                    end else begin
                        drn_en = 1'b1;
                        if (drn_tick) begin
                            timer_d = timer_q - TIMER_W'(1);
                            bonus_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= DEFAULT_TIME;
            running_q    <= 1'b0;
            time_up_q    <= 1'b0;
            bonus_q      <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            running_q    <= (state_d == StRun);
            time_up_q    <= time_up_d;
            bonus_q      <= bonus_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign timer      = timer_q;
    assign running    = running_q;
    assign time_up    = time_up_q;
    assign bonus_tick = bonus_q;
    assign drain_done = drain_done_q;

endmodule
